riscv_run_ctrl: RTL and testbench

Synthesizable run controller for RV32I core simulation and FPGA bring-up. It sequences the core reset, counts run cycles and retired instructions, and watches data-memory writes to a `tohost` address to decide pass/fail. It enforces a cycle timeout. It sits beside `riscv_top`, drives the core reset and snoops the dmem write port, so the same pass/fail logic works for single-cycle and pipelined cores.

---
 rtl/riscv_run_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: sequences the core reset, counts RUN cycles and retired
// instructions, and decides pass/fail/timeout by snooping full-word data
// memory writes to the tohost address.
module riscv_run_ctrl #(
    parameter int               XLEN         = 32,
    parameter int               RESET_CYCLES = 4,
    parameter int               MAX_CYCLES   = 100,
    parameter logic [XLEN-1:0]  TOHOST_ADDR  = XLEN'(32'h0000_1000),
    parameter int               CNT_BIT      = 32
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    input  logic                i_retire,
    input  logic                i_dmem_wr_en,
    input  logic [XLEN-1:0]     i_dmem_addr,
    input  logic [3:0]          i_dmem_byte_sel,
    input  logic [XLEN-1:0]     i_dmem_wr_data,
    output logic                o_cpu_rstn,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_fail,
    output logic                o_timeout,
    output logic [XLEN-2:0]     o_fail_code,
    output logic [CNT_BIT-1:0]  o_cycle_cnt,
    output logic [CNT_BIT-1:0]  o_instret,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_BIT-1:0] sat_inc(input logic [CNT_BIT-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_BIT'(1);
        end
    endfunction

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_BIT-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_BIT-1:0]  instret_q, instret_d;
    logic [XLEN-2:0]     fail_code_q, fail_code_d;
    logic                cpu_rstn_q, cpu_rstn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                timeout_q, timeout_d;

    logic                tohost_hit_s;
    logic                pass_hit_s;
    logic                fail_hit_s;
    logic [CNT_BIT-1:0]  cycle_inc_s;
    logic [CNT_BIT-1:0]  instret_inc_s;

    // Decode the snooped write: only full-word writes to tohost count; even data is console traffic.
    always_comb begin
        tohost_hit_s  = i_dmem_wr_en && (i_dmem_addr == TOHOST_ADDR) &&
                        (i_dmem_byte_sel == 4'b1111);
        pass_hit_s    = tohost_hit_s && (i_dmem_wr_data == XLEN'(1));
        fail_hit_s    = tohost_hit_s && i_dmem_wr_data[0] && (i_dmem_wr_data != XLEN'(1));
        cycle_inc_s   = sat_inc(cycle_cnt_q);
        instret_inc_s = sat_inc(instret_q);
    end

    // Next-state logic for the run sequence and the counters it owns.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        instret_d   = instret_q;
        fail_code_d = fail_code_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (i_start) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    instret_d   = '0;
                    fail_code_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // The terminating cycle is counted too, so the count equals the 1-based cycle number.
                cycle_cnt_d = cycle_inc_s;
                if (i_retire) begin
                    instret_d = instret_inc_s;
                end else begin
                    instret_d = instret_q;
                end
                // A terminating tohost write in the last budget cycle wins over the timeout.
                if (pass_hit_s) begin
                    state_d = ST_PASS;
                end else if (fail_hit_s) begin
                    state_d     = ST_FAIL;
                    fail_code_d = i_dmem_wr_data[XLEN-1:1];
                end else if (cycle_inc_s == CNT_BIT'(MAX_CYCLES)) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                hold_cnt_d  = '0;
                cycle_cnt_d = '0;
                instret_d   = '0;
                fail_code_d = '0;
            end
        endcase
    end

    // Status outputs follow the next state so they can be registered alongside it.
    always_comb begin
        cpu_rstn_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                cpu_rstn_d = 1'b0;
            end
            ST_HOLD: begin
                busy_d = 1'b1;
            end
            ST_RUN: begin
                busy_d     = 1'b1;
                cpu_rstn_d = 1'b1;
            end
            ST_PASS: begin
                done_d = 1'b1;
                pass_d = 1'b1;
            end
            ST_FAIL: begin
                done_d = 1'b1;
                fail_d = 1'b1;
            end
            ST_TIMEOUT: begin
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
            default: begin
                cpu_rstn_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; synchronous active-low reset returns everything to IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            instret_q   <= '0;
            fail_code_q <= '0;
            cpu_rstn_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            instret_q   <= instret_d;
            fail_code_q <= fail_code_d;
            cpu_rstn_q  <= cpu_rstn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_cpu_rstn  = cpu_rstn_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_fail      = fail_q;
    assign o_timeout   = timeout_q;
    assign o_fail_code = fail_code_q;
    assign o_cycle_cnt = cycle_cnt_q;
    assign o_instret   = instret_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed testbench for riscv_run_ctrl: a per-cycle vector table for reset,
// start timing and tohost filtering, then hand-written multi-cycle sequences.
module tb_riscv_run_ctrl;

    localparam int XLEN = 32;
    localparam int RC   = 4;
    localparam int MC   = 100;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk;
    logic        rstn, start, retire, wr_en;
    logic [31:0] addr, wdata;
    logic [3:0]  bsel;
    logic        cpu_rstn, busy, done, pass, fail, tmo;
    logic [30:0] fail_code;
    logic [31:0] cycle_cnt, instret;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    riscv_run_ctrl #(
        .XLEN(XLEN), .RESET_CYCLES(RC), .MAX_CYCLES(MC),
        .TOHOST_ADDR(TOHOST), .CNT_BIT(32)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_retire(retire),
        .i_dmem_wr_en(wr_en), .i_dmem_addr(addr), .i_dmem_byte_sel(bsel),
        .i_dmem_wr_data(wdata), .o_cpu_rstn(cpu_rstn), .o_busy(busy),
        .o_done(done), .o_pass(pass), .o_fail(fail), .o_timeout(tmo),
        .o_fail_code(fail_code), .o_cycle_cnt(cycle_cnt), .o_instret(instret),
        .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn, start, retire, wr_en;
        logic [31:0] addr;
        logic [3:0]  bsel;
        logic [31:0] data;
        logic [2:0]  st;
        logic [31:0] cnt, inst;
        logic [30:0] fc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(input logic r, s, ret, we, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d,
                                 input logic [2:0] st, input logic [31:0] cnt, inst,
                                 input logic [30:0] fc);
        vec_t v;
        v.rstn = r; v.start = s; v.retire = ret; v.wr_en = we;
        v.addr = a; v.bsel = b; v.data = d;
        v.st = st; v.cnt = cnt; v.inst = inst; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare every output against the expected state and counter values.
    task automatic chk_all(input string tag, input logic [2:0] st, input logic [31:0] cnt,
                           input logic [31:0] inst, input logic [30:0] fc);
        chk({tag, ".state"},    32'(state),     32'(st));
        chk({tag, ".cpu_rstn"}, 32'(cpu_rstn),  32'(st == 3'd2));
        chk({tag, ".busy"},     32'(busy),      32'(st == 3'd1 || st == 3'd2));
        chk({tag, ".done"},     32'(done),      32'(st == 3'd3 || st == 3'd4 || st == 3'd5));
        chk({tag, ".pass"},     32'(pass),      32'(st == 3'd3));
        chk({tag, ".fail"},     32'(fail),      32'(st == 3'd4));
        chk({tag, ".timeout"},  32'(tmo),       32'(st == 3'd5));
        chk({tag, ".cycle"},    cycle_cnt,      cnt);
        chk({tag, ".instret"},  instret,        inst);
        chk({tag, ".fcode"},    32'(fail_code), 32'(fc));
    endtask

    task automatic drive(input logic r, s, ret, we, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        rstn = r; start = s; retire = ret; wr_en = we; addr = a; bsel = b; wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse, four HOLD periods with the core in reset, then RUN.
    task automatic restart(input string tag);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        step();
        chk_all({tag, ".hold0"}, 3'd1, 32'd0, 32'd0, 31'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 0; i < RC - 1; i++) begin
            step();
            chk_all({tag, ".hold"}, 3'd1, 32'd0, 32'd0, 31'd0);
        end
        step();
        chk_all({tag, ".run0"}, 3'd2, 32'd0, 32'd0, 31'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

        //              rstn  start retire we    addr          bsel     data           st    cnt    inst   fc
        vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd0, 32'd0, 32'd0, 31'd0);
        vecs[1]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd0, 32'd0, 32'd0, 31'd0);
        vecs[2]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd1, 32'd0, 32'd0, 31'd0);
        vecs[3]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd1, 32'd0, 32'd0, 31'd0);
        vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd1, 32'd0, 32'd0, 31'd0);
        vecs[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd1, 32'd0, 32'd0, 31'd0);
        vecs[6]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd2, 32'd0, 32'd0, 31'd0);
        vecs[7]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'd0,        4'd0,    32'd0,         3'd2, 32'd1, 32'd1, 31'd0);
        vecs[8]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'd0,        4'd0,    32'd0,         3'd2, 32'd2, 32'd2, 31'd0);
        vecs[9]  = mkv(1'b1, 1'b0, 1'b1, 1'b1, TOHOST,       4'b1111, 32'h10,        3'd2, 32'd3, 32'd3, 31'd0);
        vecs[10] = mkv(1'b1, 1'b0, 1'b1, 1'b1, TOHOST,       4'b0001, 32'd1,         3'd2, 32'd4, 32'd4, 31'd0);
        vecs[11] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 32'h1004,     4'b1111, 32'd1,         3'd2, 32'd5, 32'd5, 31'd0);
        vecs[12] = mkv(1'b1, 1'b0, 1'b1, 1'b0, TOHOST,       4'b1111, 32'd1,         3'd2, 32'd6, 32'd6, 31'd0);
        vecs[13] = mkv(1'b1, 1'b0, 1'b1, 1'b1, TOHOST,       4'b1111, 32'h0000_000B, 3'd4, 32'd7, 32'd7, 31'd5);
        vecs[14] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        4'd0,    32'd0,         3'd4, 32'd7, 32'd7, 31'd5);
        vecs[15] = mkv(1'b1, 1'b0, 1'b1, 1'b1, TOHOST,       4'b1111, 32'd1,         3'd4, 32'd7, 32'd7, 31'd5);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rstn, vecs[i].start, vecs[i].retire, vecs[i].wr_en,
                  vecs[i].addr, vecs[i].bsel, vecs[i].data);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].inst, vecs[i].fc);
        end

        // Pass on RUN cycle 37 with a retire every cycle; restart out of FAIL clears the fail code.
        restart("pass37");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 1; i <= 36; i++) begin
            step();
            chk($sformatf("pass37.cnt%0d", i), cycle_cnt, 32'(i));
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, TOHOST, 4'b1111, 32'd1);
        step();
        chk_all("pass37.end", 3'd3, 32'd37, 32'd37, 31'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0);
        step();
        chk_all("pass37.sticky", 3'd3, 32'd37, 32'd37, 31'd0);

        // Timeout with no tohost write; restart from PASS clears the counters.
        restart("tmo");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 1; i <= MC - 1; i++) step();
        chk_all("tmo.99", 3'd2, 32'd99, 32'd0, 31'd0);
        step();
        chk_all("tmo.end", 3'd5, 32'd100, 32'd0, 31'd0);
        step();
        chk_all("tmo.sticky", 3'd5, 32'd100, 32'd0, 31'd0);

        // Pass write on the last budget cycle beats the timeout.
        restart("prec");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 1; i <= MC - 1; i++) step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, TOHOST, 4'b1111, 32'd1);
        step();
        chk_all("prec.end", 3'd3, 32'd100, 32'd0, 31'd0);

        // Retire gating: 1,0,1,0 over 10 cycles, pass on cycle 11 without retiring.
        restart("ret");
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0, (i % 2) == 1, 1'b0, 32'd0, 4'd0, 32'd0);
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, TOHOST, 4'b1111, 32'd1);
        step();
        chk_all("ret.end", 3'd3, 32'd11, 32'd5, 31'd0);

        // Fail code keeps the upper bits of the written word.
        restart("hifail");
        drive(1'b1, 1'b0, 1'b1, 1'b1, TOHOST, 4'b1111, 32'h8000_0003);
        step();
        chk_all("hifail.end", 3'd4, 32'd1, 32'd1, 31'h4000_0001);

        // Reset asserted during RUN cycle 20 returns to IDLE with every output cleared.
        restart("rst");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 1; i <= 19; i++) step();
        chk_all("rst.19", 3'd2, 32'd19, 32'd19, 31'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0);
        step();
        chk_all("rst.idle", 3'd0, 32'd0, 32'd0, 31'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0);
        step();
        chk_all("rst.stay", 3'd0, 32'd0, 32'd0, 31'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
